wl_skid: RTL

WL_SKID -- requirements
Module: wl_skid

---
 rtl/wl_pkg.sv | 29 ++
 rtl/wl_skid.sv | 107 ++++++++++
 2 files changed

// File: rtl/wl_pkg.sv
// Shared definitions for the wl_skid two-entry skid buffer.
//   wl_state_e : occupancy state (empty / one word / two words)
//   Cnt*       : encodings presented on the cnt output
//   state_cnt  : maps a state onto its cnt encoding
package wl_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StBusy  = 2'b01,
        StFull  = 2'b10
    } wl_state_e;

    localparam logic [1:0] CntEmpty = 2'd0;
    localparam logic [1:0] CntBusy  = 2'd1;
    localparam logic [1:0] CntFull  = 2'd2;

    function automatic logic [1:0] state_cnt(wl_state_e st);
        logic [1:0] c;
        c = CntEmpty;
        unique case (st)
            StEmpty: c = CntEmpty;
            StBusy:  c = CntBusy;
            StFull:  c = CntFull;
            default: c = CntEmpty;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/wl_skid.sv
// Two-entry skid buffer with fully registered handshake outputs.
// A main register drives m_data; a skid register catches the one word that
// can arrive while downstream stalls. s_ready and m_valid come straight from
// flops, so there is no combinational path from m_ready to s_ready.
//
// Ports
//   clk      : clock, all state changes on its rising edge
//   rst      : synchronous active-high reset
//   s_valid  : upstream word valid
//   s_ready  : buffer can accept (registered)
//   s_data   : upstream payload, DW bits
//   m_valid  : downstream word valid (registered)
//   m_ready  : downstream accepts
//   m_data   : downstream payload (registered)
//   cnt      : words held, 0..2
module wl_skid
    import wl_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    cnt
);

    wl_state_e     state_q, state_d;
    logic [DW-1:0] main_q, main_d;
    logic [DW-1:0] skid_q, skid_d;
    logic          s_ready_q;
    logic          m_valid_q;
    logic [1:0]    cnt_q;

    logic accept;
    logic deliver;

    // Handshakes use the registered flags, so s_ready stays low for the
    // first cycle out of reset even though the state is already empty.
    assign accept  = s_valid & s_ready_q;
    assign deliver = m_valid_q & m_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    main_d  = s_data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (accept && deliver) begin
                    main_d = s_data;
                end else if (accept) begin
                    skid_d  = s_data;
                    state_d = StFull;
                end else if (deliver) begin
                    // main keeps its last value; m_data is don't-care now
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // s_ready is low here, so s_valid/s_data play no part
                if (deliver) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    // Output flags are computed from the next state so they line up with
    // the state register after every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StEmpty;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            cnt_q     <= CntEmpty;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != StFull);
            m_valid_q <= (state_d != StEmpty);
            cnt_q     <= state_cnt(state_d);
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;
    assign cnt     = cnt_q;

endmodule
